mux_rr_arbiter_4: RTL and testbench
===================================

Name: mux_rr_arbiter_4

Overview:
- Round-robin arbiter that shares one 4:1 datapath mux between four requesters.
- Converts requests into a one-hot grant and a registered 2-bit select.
- Holds each grant until the requester releases, the resource signals done, or a hold limit expires.
- Sits in front of shared resources (e.g. data-memory port, register-file write port) in the single-cycle/multicycle core; the output is the selected requester's data qualified by a valid flag.

Parameters:
- DATA_LENGTH, 32, width of each requester data bus and of data_out.
- MAX_HOLD, 8, maximum consecutive cycles one grant is held; legal values 1..255.
- CNT_WIDTH, 8, hold counter width; must satisfy 2^CNT_WIDTH > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i = requester i.
- done  input  1  shared resource finished the current transaction; sampled only in GRANT.
- data_a  input  DATA_LENGTH  requester 0 data.
- data_b  input  DATA_LENGTH  requester 1 data.
- data_c  input  DATA_LENGTH  requester 2 data.
- data_d  input  DATA_LENGTH  requester 3 data.
- gnt  output  4  one-hot grant, registered; all zero when no grant.
- sel  output  2  registered mux select; equals index of current or most recent grantee.
- data_out  output  DATA_LENGTH  muxed data chosen by sel.
- valid_out  output  1  high exactly while gnt is non-zero.
- preempt  output  1  one-cycle pulse when a grant is ended by the hold limit.

Behaviour:
- Reset (asynchronous, active-high, one clock):
  - Asserting rst forces immediately: state=IDLE, gnt=4'b0000, sel=2'b00, valid_out=0, preempt=0, hold_cnt=0, last=2'b11.
  - last=2'b11 gives requester 0 highest priority first.
  - Reset mid-grant drops gnt at once; no done or preempt is issued.
- State IDLE:
  - gnt=0, valid_out=0, hold_cnt=0.
  - If req!=0: search indices last+1, last+2, last+3, last+4 (mod 4); take the first with req set.
  - Register that index into sel and its one-hot into gnt; go to GRANT.
  - Latency: req high before edge N gives gnt/valid_out visible from edge N.
  - If req==0: stay in IDLE; sel holds its value.
- State GRANT:
  - gnt and sel hold steady; hold_cnt increments by 1 each cycle.
  - Exit condition (evaluated each edge): done=1, OR req[sel]=0, OR hold_cnt==MAX_HOLD-1.
  - On exit: last<=sel, gnt<=0, hold_cnt<=0, state<=IDLE.
  - Mandatory dead cycle: at least one IDLE cycle (gnt=0) between consecutive grants, for resource turnaround.
  - preempt<=1 for one cycle only when the exit is caused solely by the hold limit, i.e. done=0 and req[sel]=1. Otherwise preempt<=0.
- Priority and fairness:
  - The just-served requester has lowest priority at the next arbitration, so a preempted requester goes to the back of the rotation.
  - Any continuously requesting index is granted within 4 grants.
- req changes during GRANT on other indices are ignored until the next IDLE.
- Simultaneous events:
  - done and hold limit in the same cycle → normal release, preempt=0.
  - done and req drop in the same cycle → single release.
- MAX_HOLD=1: every grant lasts exactly one cycle; preempt pulses if the requester is still asserting and done=0.
- Datapath:
  - data_out is purely combinational from sel (00→a, 01→b, 10→c, 11→d).
  - data_out is valid only when valid_out=1; outside that it shows the last selected source.
- Counter never wraps: it is cleared on exit before reaching 2^CNT_WIDTH-1.

Decomposition:
- Shared package: state encoding constants IDLE=1'b0, GRANT=1'b1; select constants SEL_A..SEL_D (2'b00..2'b11).
- Sub-module: instantiate the existing parametric 4:1 mux Mux_4_1_Param (DATA_LENGTH passed through) for data_out.
- Arbitration FSM, rotating priority search and hold counter stay in this module.

Test Plan:
- Reset: assert rst mid-grant → same cycle gnt=0000, valid_out=0, sel=00; after release, req=1111 → first gnt=0001, sel=00.
- Rotation: hold req=1111, done pulsed each grant cycle → gnt sequence 0001, 0010, 0100, 1000, 0001, with one gnt=0000 cycle between each.
- Data path: data_a..d=0x11111111/0x22222222/0x33333333/0x44444444, req=0100 → valid_out=1, sel=10, data_out=0x33333333.
- Hold limit: MAX_HOLD=8, req=0011 steady, done=0 → gnt=0001 for exactly 8 cycles, preempt=1 for one cycle, then 1 idle cycle, then gnt=0010.
- Early release: req[1] drops after 3 grant cycles → gnt=0000 next edge, preempt=0, last=01; then req=0011 → gnt=0001.
- Simultaneous: done=1 on the cycle hold_cnt==MAX_HOLD-1 → release with preempt=0; with MAX_HOLD=1 and req=0001 held → gnt alternates 0001/0000 and preempt pulses each grant.

Source files
------------

// File: rtl/mux_rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   state_e   : arbitration FSM encoding (idle = 1'b0, grant = 1'b1)
//   SEL_A..D  : mux select codes for requesters 0..3
//   rr_pick   : rotating-priority search, returns {found, index}
//   sel2onehot: index to one-hot grant vector
package mux_rr_arbiter_4_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // Searches last+1, last+2, last+3, last+4 (mod 4). The loop runs from the
    // farthest offset down so the nearest requesting index is written last.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [2:0] pick;
        pick = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] sel2onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_4_if.sv
// Bus between the four requesters / shared resource and the arbiter.
//   req, done, data_a..data_d        : requester/resource side to arbiter
//   gnt, sel, data_out, valid_out,
//   preempt                          : arbiter back to requesters/resource
// master = requester/resource side, slave = arbiter side.
interface mux_rr_arbiter_4_if #(
    parameter int unsigned DATA_LENGTH = 32
);
    logic [3:0]             req;
    logic                   done;
    logic [DATA_LENGTH-1:0] data_a;
    logic [DATA_LENGTH-1:0] data_b;
    logic [DATA_LENGTH-1:0] data_c;
    logic [DATA_LENGTH-1:0] data_d;
    logic [3:0]             gnt;
    logic [1:0]             sel;
    logic [DATA_LENGTH-1:0] data_out;
    logic                   valid_out;
    logic                   preempt;

    modport master (
        output req, done, data_a, data_b, data_c, data_d,
        input  gnt, sel, data_out, valid_out, preempt
    );

    modport slave (
        input  req, done, data_a, data_b, data_c, data_d,
        output gnt, sel, data_out, valid_out, preempt
    );
endinterface

// File: rtl/Mux_4_1_Param.sv
// Parametric 4:1 combinational mux.
//   i_sel              : 2-bit select (00 -> a, 01 -> b, 10 -> c, 11 -> d)
//   i_data_a..i_data_d : DATA_LENGTH-bit sources
//   o_data             : selected source
module Mux_4_1_Param
    import mux_rr_arbiter_4_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 32
) (
    input  logic [1:0]             i_sel,
    input  logic [DATA_LENGTH-1:0] i_data_a,
    input  logic [DATA_LENGTH-1:0] i_data_b,
    input  logic [DATA_LENGTH-1:0] i_data_c,
    input  logic [DATA_LENGTH-1:0] i_data_d,
    output logic [DATA_LENGTH-1:0] o_data
);

    always_comb begin
        o_data = i_data_a;
        case (i_sel)
            SEL_A:   o_data = i_data_a;
            SEL_B:   o_data = i_data_b;
            SEL_C:   o_data = i_data_c;
            SEL_D:   o_data = i_data_d;
            default: o_data = i_data_a;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter_4.sv
// Round-robin arbiter sharing one 4:1 datapath mux between four requesters.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of mux_rr_arbiter_4_if
//         in : req[3:0], done, data_a..data_d
//         out: gnt[3:0] (one-hot, registered), sel[1:0] (registered),
//              data_out (mux of sel), valid_out (gnt != 0),
//              preempt (one-cycle pulse when the hold limit ends a grant)
// Every grant is followed by at least one idle cycle for resource turnaround.
module mux_rr_arbiter_4
    import mux_rr_arbiter_4_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned MAX_HOLD    = 8,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux_rr_arbiter_4_if.slave   bus
);

    state_e               r_state;
    logic [3:0]           r_gnt;
    logic [1:0]           r_sel;
    logic [1:0]           r_last;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_preempt;

    state_e               w_state_d;
    logic [3:0]           w_gnt_d;
    logic [1:0]           w_sel_d;
    logic [1:0]           w_last_d;
    logic [CNT_WIDTH-1:0] w_cnt_d;
    logic                 w_preempt_d;

    logic [2:0]           w_pick;
    logic                 w_req_sel;
    logic                 w_hold_hit;

    assign w_pick     = rr_pick(bus.req, r_last);
    assign w_req_sel  = bus.req[r_sel];
    assign w_hold_hit = (r_cnt == CNT_WIDTH'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_gnt     <= 4'b0000;
            r_sel     <= SEL_A;
            r_last    <= SEL_D;     // requester 0 wins the first arbitration
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_gnt     <= w_gnt_d;
            r_sel     <= w_sel_d;
            r_last    <= w_last_d;
            r_cnt     <= w_cnt_d;
            r_preempt <= w_preempt_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_gnt_d     = r_gnt;
        w_sel_d     = r_sel;
        w_last_d    = r_last;
        w_cnt_d     = r_cnt;
        w_preempt_d = 1'b0;

        case (r_state)
            StIdle: begin
                w_gnt_d = 4'b0000;
                w_cnt_d = '0;
                if (w_pick[2]) begin
                    w_sel_d   = w_pick[1:0];
                    w_gnt_d   = sel2onehot(w_pick[1:0]);
                    w_state_d = StGrant;
                end
            end
            StGrant: begin
                if (bus.done || !w_req_sel || w_hold_hit) begin
                    w_last_d    = r_sel;
                    w_gnt_d     = 4'b0000;
                    w_cnt_d     = '0;
                    w_state_d   = StIdle;
                    // Only the hold limit can end a grant that is still
                    // requested and not done.
                    w_preempt_d = !bus.done && w_req_sel;
                end else begin
                    w_cnt_d = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
                w_gnt_d   = 4'b0000;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.valid_out = |r_gnt;
    assign bus.preempt   = r_preempt;

    Mux_4_1_Param #(
        .DATA_LENGTH(DATA_LENGTH)
    ) u_mux (
        .i_sel    (r_sel),
        .i_data_a (bus.data_a),
        .i_data_b (bus.data_b),
        .i_data_c (bus.data_c),
        .i_data_d (bus.data_d),
        .o_data   (bus.data_out)
    );

endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
// Scoreboard bench for mux_rr_arbiter_4: two instances (hold limits 8 and 1)
// share the same stimulus; a behavioural model pushes expected outputs and a
// monitor compares them one clock edge later.
module tb_mux_rr_arbiter_4;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic        valid;
        logic        preempt;
        logic [31:0] data;
    } obs_t;

    logic clk;
    logic rst;

    mux_rr_arbiter_4_if #(.DATA_LENGTH(32)) bus8 ();
    mux_rr_arbiter_4_if #(.DATA_LENGTH(32)) bus1 ();

    mux_rr_arbiter_4 #(
        .DATA_LENGTH(32),
        .MAX_HOLD   (8),
        .CNT_WIDTH  (8)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    mux_rr_arbiter_4 #(
        .DATA_LENGTH(32),
        .MAX_HOLD   (1),
        .CNT_WIDTH  (8)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    obs_t exp_q8[$];
    obs_t exp_q1[$];

    // Model state per instance (0: hold limit 8, 1: hold limit 1).
    int          owner[2];   // current grantee, -1 when none
    int          held[2];    // cycles the current grant has been visible
    int          served[2];  // most recently served requester
    int          msel[2];    // current or most recent grantee
    logic [31:0] dat[4];
    logic        keep_data = 1'b0;

    function automatic obs_t obs8();
        return {bus8.gnt, bus8.sel, bus8.valid_out, bus8.preempt, bus8.data_out};
    endfunction

    function automatic obs_t obs1();
        return {bus1.gnt, bus1.sel, bus1.valid_out, bus1.preempt, bus1.data_out};
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got gnt=%b sel=%0d valid=%b preempt=%b data=%h, need gnt=%b sel=%0d valid=%b preempt=%b data=%h",
                     name, $time, act.gnt, act.sel, act.valid, act.preempt, act.data,
                     exp.gnt, exp.sel, exp.valid, exp.preempt, exp.data);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %0d, need %0d", name, $time, act, exp);
        end
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic step_model(input int k, input int mh, input logic r,
                              input logic [3:0] rq, input logic dn, output obs_t o);
        logic pre;
        bit   found;
        int   idx;
        pre = 1'b0;
        if (r) begin
            owner[k] = -1; held[k] = 0; served[k] = 3; msel[k] = 0;
        end else if (owner[k] < 0) begin
            found = 0;
            for (int i = 1; i <= 4; i++) begin
                idx = (served[k] + i) % 4;
                if (!found && rq[idx]) begin
                    found = 1; owner[k] = idx; msel[k] = idx; held[k] = 1;
                end
            end
        end else if (dn || !rq[owner[k]] || held[k] == mh) begin
            pre       = !dn && rq[owner[k]];
            served[k] = owner[k];
            owner[k]  = -1;
            held[k]   = 0;
        end else begin
            held[k]++;
        end
        o.gnt     = (owner[k] < 0) ? 4'b0000 : 4'(1 << owner[k]);
        o.sel     = 2'(msel[k]);
        o.valid   = (owner[k] >= 0);
        o.preempt = pre;
        o.data    = dat[msel[k]];
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic dn);
        obs_t e8, e1;
        @(negedge clk);
        if (!keep_data) begin
            for (int i = 0; i < 4; i++) dat[i] = $urandom;
        end
        rst = r;
        bus8.req = rq; bus8.done = dn;
        bus1.req = rq; bus1.done = dn;
        bus8.data_a = dat[0]; bus8.data_b = dat[1]; bus8.data_c = dat[2]; bus8.data_d = dat[3];
        bus1.data_a = dat[0]; bus1.data_b = dat[1]; bus1.data_c = dat[2]; bus1.data_d = dat[3];
        step_model(0, 8, r, rq, dn, e8);
        step_model(1, 1, r, rq, dn, e1);
        exp_q8.push_back(e8);
        exp_q1.push_back(e1);
    endtask

    // Monitor: compare each edge's outputs against the queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q8.size() > 0) check_obs("sb_hold8", obs8(), exp_q8.pop_front());
            if (exp_q1.size() > 0) check_obs("sb_hold1", obs1(), exp_q1.pop_front());
        end
    end

    initial begin
        obs_t e;
        int   g0_cycles;
        int   pulses;

        for (int i = 0; i < 4; i++) dat[i] = 32'h0;
        rst = 1'b1;
        bus8.req = 4'b0; bus8.done = 1'b0;
        bus1.req = 4'b0; bus1.done = 1'b0;
        bus8.data_a = '0; bus8.data_b = '0; bus8.data_c = '0; bus8.data_d = '0;
        bus1.data_a = '0; bus1.data_b = '0; bus1.data_c = '0; bus1.data_d = '0;
        #1;
        step_model(0, 8, 1'b1, 4'b0, 1'b0, e);
        check_obs("reset_hold8", obs8(), e);
        step_model(1, 1, 1'b1, 4'b0, 1'b0, e);
        check_obs("reset_hold1", obs1(), e);

        // Rotation: all requesting, done every grant cycle.
        for (int i = 0; i < 10; i++) drive(1'b0, 4'b1111, 1'b1);

        // Datapath: requester 2 alone with fixed source data.
        drive(1'b0, 4'b0000, 1'b1);
        drive(1'b0, 4'b0000, 1'b1);
        keep_data = 1'b1;
        dat[0] = 32'h11111111; dat[1] = 32'h22222222;
        dat[2] = 32'h33333333; dat[3] = 32'h44444444;
        drive(1'b0, 4'b0100, 1'b0);
        @(posedge clk);
        #2;
        check_obs("datapath", obs8(), {4'b0100, 2'b10, 1'b1, 1'b0, 32'h33333333});
        keep_data = 1'b0;
        drive(1'b0, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);

        // Hold limit: requesters 0 and 1 steady, no done.
        g0_cycles = 0;
        pulses    = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 4'b0011, 1'b0);
            @(posedge clk);
            #2;
            if (bus8.gnt == 4'b0001) g0_cycles++;
            if (bus8.preempt) pulses++;
            if (i == 9) check_int("hold_next_grant", int'(bus8.gnt), 2);
        end
        check_int("hold_cycles", g0_cycles, 8);
        check_int("hold_preempt_pulses", pulses, 1);

        // Early release of requester 1, then re-arbitration.
        drive(1'b0, 4'b0000, 1'b1);
        drive(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 4'b0010, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        drive(1'b0, 4'b0011, 1'b0);
        drive(1'b0, 4'b0011, 1'b0);

        // done coinciding with the hold limit.
        drive(1'b0, 4'b0000, 1'b1);
        drive(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, 4'b0001, (i == 8));
        for (int i = 0; i < 8; i++) drive(1'b0, 4'b0001, 1'b0);

        // Reset mid-grant.
        drive(1'b0, 4'b1111, 1'b0);
        drive(1'b0, 4'b1111, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        step_model(0, 8, 1'b1, 4'b1111, 1'b0, e);
        check_obs("reset_mid_hold8", obs8(), e);
        step_model(1, 1, 1'b1, 4'b1111, 1'b0, e);
        check_obs("reset_mid_hold1", obs1(), e);
        drive(1'b1, 4'b1111, 1'b0);
        drive(1'b0, 4'b1111, 1'b0);
        @(posedge clk);
        #2;
        check_int("post_reset_gnt", int'(bus8.gnt), 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));
        end
        drive(1'b0, 4'b0000, 1'b0);

        @(posedge clk);
        #3;
        check_int("queue_drain", exp_q8.size() + exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
